// File: rtl/vram_scheduler.sv
`default_nettype none
// ============================================================================
// vram_scheduler
//   Shares a single-port pipelined video RAM between display refresh (one read
//   per 4-pixel word, serialised to pixels) and one valid/ready writer.
//   Optional double buffering is enabled by defining VRAM_DBUF_EN.
// Rev 1.0
// ============================================================================
module vram_scheduler #(
  parameter int PIX_W    = 8,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int ADDR_W   = 18,
  parameter int FB_BASE  = 0,
  parameter int MEM_LAT  = 2
) (
  input  logic                 vclock,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [10:0]          vcount,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 blank,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [4*PIX_W-1:0]   wr_data,
  output logic                 wr_ack,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [4*PIX_W-1:0]   mem_din,
  input  logic [4*PIX_W-1:0]   mem_dout,
  output logic [PIX_W-1:0]     pix_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
`ifdef VRAM_DBUF_EN
  input  logic                 buf_swap,
  output logic                 front_buf,
`endif
  output logic                 blank_out
);

  localparam int                WORD_W     = 4 * PIX_W;
  localparam int                D          = MEM_LAT + 2;
  localparam logic [10:0]       c_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]       c_V_ACT    = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] c_FB_BASE  = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] c_FB_WORDS = ADDR_W'(H_ACTIVE / 4 * V_ACTIVE);

  logic                w_slot;
  logic [ADDR_W-1:0]   w_base;
  logic                w_load;
  logic [PIX_W-1:0]    w_pix_nxt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_iss;
  logic [MEM_LAT-1:0]  r_vld;
  logic [WORD_W-1:0]   r_sh;
  logic [PIX_W-1:0]    r_pix;
  logic [D-1:0]        r_hs_dly;
  logic [D-1:0]        r_vs_dly;
  logic [D-1:0]        r_bl_dly;

  assign w_slot = (hcount[1:0] == 2'b00) && (hcount < c_H_ACT) && (vcount < c_V_ACT);
  assign wr_ack = wr_req & ~w_slot & ~reset;

`ifdef VRAM_DBUF_EN
  logic r_front;
  logic r_pend;

  // A swap only takes effect at the start of vertical blank; extra pulses merge.
  always_ff @(posedge vclock) begin
    if (reset) begin
      r_front <= 1'b0;
      r_pend  <= 1'b0;
    end else if ((vcount == c_V_ACT) && (hcount == 11'd0) && r_pend) begin
      r_front <= ~r_front;
      r_pend  <= buf_swap;
    end else if (buf_swap) begin
      r_pend  <= 1'b1;
    end
  end

  assign front_buf = r_front;
  assign w_base    = r_front ? (c_FB_BASE + c_FB_WORDS) : c_FB_BASE;
`else
  assign w_base    = c_FB_BASE;
`endif

  // Lines are contiguous, so a running counter reloaded in vblank replaces y*stride.
  always_ff @(posedge vclock) begin
    if (reset)                  r_rd_addr <= c_FB_BASE;
    else if (vcount >= c_V_ACT) r_rd_addr <= w_base;
    else if (w_slot)            r_rd_addr <= r_rd_addr + 1'b1;
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
    end else if (w_slot) begin
      mem_addr <= r_rd_addr;
      mem_we   <= 1'b0;
    end else if (wr_ack) begin
      mem_addr <= wr_addr;
      mem_we   <= 1'b1;
      mem_din  <= wr_data;
    end else begin
      mem_we   <= 1'b0;
    end
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_rd_iss <= 1'b0;
      r_vld    <= '0;
    end else begin
      r_rd_iss <= w_slot;
      r_vld[0] <= r_rd_iss;
      for (int i = 1; i < MEM_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_hs_dly <= '1;
      r_vs_dly <= '1;
      r_bl_dly <= '1;
    end else begin
      r_hs_dly <= {r_hs_dly[D-2:0], hsync};
      r_vs_dly <= {r_vs_dly[D-2:0], vsync};
      r_bl_dly <= {r_bl_dly[D-2:0], blank};
    end
  end

  // Pixel 0 goes straight to the output register; the shifter keeps the rest.
  assign w_load    = r_vld[MEM_LAT-1];
  assign w_pix_nxt = w_load ? mem_dout[PIX_W-1:0] : r_sh[PIX_W-1:0];

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_sh  <= '0;
      r_pix <= '0;
    end else begin
      r_sh  <= w_load ? (mem_dout >> PIX_W) : (r_sh >> PIX_W);
      r_pix <= r_bl_dly[D-2] ? '0 : w_pix_nxt;
    end
  end

  assign pix_out   = r_pix;
  assign hsync_out = r_hs_dly[D-1];
  assign vsync_out = r_vs_dly[D-1];
  assign blank_out = r_bl_dly[D-1];

endmodule
`default_nettype wire
